// File: rtl/pc_pkg.sv
// Shared types and default constants for the program-counter generator.
// Holds the FSM state encoding, the next-PC select encoding and the redirect priority order.
package pc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } pc_state_e;

  typedef enum logic [2:0] {
    SEL_HOLD   = 3'd0,
    SEL_SEQ    = 3'd1,
    SEL_BRANCH = 3'd2,
    SEL_JUMP   = 3'd3,
    SEL_RET    = 3'd4,
    SEL_EXC    = 3'd5
  } pc_sel_e;

  localparam int unsigned DEF_ADDR_W     = 32;
  localparam int unsigned DEF_INC        = 4;
  localparam int unsigned DEF_RESET_ADDR = 0;
  localparam int unsigned DEF_EXC_ADDR   = 32'h100;
  localparam int unsigned DEF_RAS_DEPTH  = 4;

  // Redirect priority: exception > return > jump > branch > sequential > hold.
  function automatic pc_sel_e pc_select(input logic exc, input logic ret, input logic jump,
                                        input logic branch, input logic seq);
    pc_sel_e sel;
    if (exc)         sel = SEL_EXC;
    else if (ret)    sel = SEL_RET;
    else if (jump)   sel = SEL_JUMP;
    else if (branch) sel = SEL_BRANCH;
    else if (seq)    sel = SEL_SEQ;
    else             sel = SEL_HOLD;
    return sel;
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-side and control-side signals of the PC generator, bundled as one interface.
// master is the PC generator; slave is the control unit / fetch port driving it.
interface pc_gen_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              en;
  logic              halt;
  logic              stall;
  logic              fetch_ready;
  logic              fetch_valid;
  logic [ADDR_W-1:0] addr;
  logic              exc;
  logic              ret;
  logic              jump;
  logic [ADDR_W-1:0] jump_target;
  logic              call;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic              ras_full;
  logic              ras_empty;
  logic              ras_underflow;

  modport master (
    input  en, halt, stall, fetch_ready, exc, ret, jump, jump_target, call,
           branch_taken, branch_target,
    output fetch_valid, addr, ras_full, ras_empty, ras_underflow
  );

  modport slave (
    output en, halt, stall, fetch_ready, exc, ret, jump, jump_target, call,
           branch_taken, branch_target,
    input  fetch_valid, addr, ras_full, ras_empty, ras_underflow
  );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// a pop when empty leaves the stack untouched and raises a one-cycle underflow pulse.
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] push_data_i,
  output logic [ADDR_W-1:0] pop_data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              underflow_o
);

  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(RAS_DEPTH);

  logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
  logic [PTR_W-1:0]  sp_q, sp_d, top_idx;
  logic [PTR_W:0]    cnt_q, cnt_d;
  logic              full_q, empty_q, underflow_q;

  // sp_q points at the next free slot; with a power-of-two depth it wraps for free.
  assign top_idx    = sp_q - PTR_W'(1);
  assign pop_data_o = mem_q[top_idx];

  always_comb begin
    sp_d  = sp_q;
    cnt_d = cnt_q;
    if (pop_i) begin
      if (cnt_q != '0) begin
        sp_d  = sp_q - PTR_W'(1);
        cnt_d = cnt_q - (PTR_W + 1)'(1);
      end
    end else if (push_i) begin
      sp_d = sp_q + PTR_W'(1);
      if (cnt_q != DEPTH_CNT) cnt_d = cnt_q + (PTR_W + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !pop_i) mem_q[sp_q] <= push_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q        <= '0;
      cnt_q       <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      underflow_q <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      cnt_q       <= cnt_d;
      full_q      <= (cnt_d == DEPTH_CNT);
      empty_q     <= (cnt_d == '0);
      underflow_q <= pop_i && (cnt_q == '0);
    end
  end

  assign full_o      = full_q;
  assign empty_o     = empty_q;
  assign underflow_o = underflow_q;

endmodule

// File: rtl/pc_gen.sv
// Instruction-fetch program counter: IDLE/RUN/HALTED fetch FSM, prioritised next-PC mux
// and the PC register, with a return-address stack for call/return redirects.
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned       ADDR_W     = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] INC        = ADDR_W'(DEF_INC),
  parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(DEF_RESET_ADDR),
  parameter logic [ADDR_W-1:0] EXC_ADDR   = ADDR_W'(DEF_EXC_ADDR),
  parameter int unsigned       RAS_DEPTH  = DEF_RAS_DEPTH
) (
  input logic       clk,
  input logic       rst,
  pc_gen_if.master  bus
);

  pc_state_e         state_q;
  logic              fetch_valid_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] seq_addr;
  logic              advance;
  pc_sel_e           sel;
  logic              ras_push, ras_pop;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_full, ras_empty, ras_underflow;

  assign seq_addr = addr_q + INC;

  // A fetch is consumed only when it was offered, accepted and not frozen.
  always_comb begin
    advance  = (state_q == ST_RUN) && fetch_valid_q && bus.fetch_ready && !bus.stall;
    sel      = pc_select(bus.exc, bus.ret, bus.jump, bus.branch_taken, advance);
    ras_pop  = (sel == SEL_RET);
    ras_push = (sel == SEL_JUMP) && bus.call;
  end

  always_comb begin
    addr_d = addr_q;
    case (sel)
      SEL_EXC:    addr_d = EXC_ADDR;
      SEL_RET:    addr_d = ras_empty ? RESET_ADDR : ras_top;
      SEL_JUMP:   addr_d = bus.jump_target;
      SEL_BRANCH: addr_d = bus.branch_target;
      SEL_SEQ:    addr_d = seq_addr;
      default:    addr_d = addr_q;
    endcase
  end

  pc_ras #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst         (rst),
    .push_i      (ras_push),
    .pop_i       (ras_pop),
    .push_data_i (seq_addr),
    .pop_data_o  (ras_top),
    .full_o      (ras_full),
    .empty_o     (ras_empty),
    .underflow_o (ras_underflow)
  );

  // Redirects update addr in every state; the FSM only gates fetch_valid and sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      fetch_valid_q <= 1'b0;
      addr_q        <= RESET_ADDR;
    end else begin
      addr_q <= addr_d;
      case (state_q)
        ST_IDLE: begin
          if (bus.en) begin
            state_q       <= ST_RUN;
            fetch_valid_q <= !bus.stall;
          end else begin
            fetch_valid_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (bus.halt) begin
            state_q       <= ST_HALTED;
            fetch_valid_q <= 1'b0;
          end else begin
            fetch_valid_q <= !bus.stall;
          end
        end
        ST_HALTED: begin
          if (bus.en) begin
            state_q       <= ST_RUN;
            fetch_valid_q <= !bus.stall;
          end else begin
            fetch_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= ST_IDLE;
          fetch_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fetch_valid   = fetch_valid_q;
  assign bus.addr          = addr_q;
  assign bus.ras_full      = ras_full;
  assign bus.ras_empty     = ras_empty;
  assign bus.ras_underflow = ras_underflow;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed steps and a random phase, compared against a
// queue-based behavioural model of the fetch PC; a second 8-bit instance covers PC wrap.
module tb_pc_gen;

  localparam int M_IDLE = 0, M_RUN = 1, M_HALTED = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_gen_if #(.ADDR_W(32)) bus32 ();
  pc_gen_if #(.ADDR_W(8))  bus8 ();

  pc_gen #(.ADDR_W(32), .INC(32'd4), .RESET_ADDR(32'd0), .EXC_ADDR(32'h100), .RAS_DEPTH(4))
    dut32 (.clk(clk), .rst(rst), .bus(bus32));

  pc_gen #(.ADDR_W(8), .INC(8'd4), .RESET_ADDR(8'd0), .EXC_ADDR(8'hE0), .RAS_DEPTH(4))
    dut8 (.clk(clk), .rst(rst), .bus(bus8));

  logic        en, halt, stall, fr, exc, ret, jump, call, br;
  logic [31:0] jt, bt;

  int          m_mode;
  logic [31:0] m_pc;
  logic        m_valid, m_uf;
  logic [31:0] m_ras[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic clear_in();
    en = 0; halt = 0; stall = 0; fr = 0; exc = 0; ret = 0; jump = 0; call = 0; br = 0;
    jt = '0; bt = '0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Behavioural model: the stack is a bounded queue, the PC a plain integer.
  task automatic model_update();
    logic adv;
    adv  = (m_mode == M_RUN) && m_valid && fr && !stall;
    m_uf = 1'b0;
    if (rst) begin
      m_pc = 32'd0; m_mode = M_IDLE; m_valid = 1'b0; m_ras.delete();
      return;
    end
    if (exc) m_pc = 32'h100;
    else if (ret) begin
      if (m_ras.size() == 0) begin
        m_pc = 32'd0; m_uf = 1'b1;
      end else m_pc = m_ras.pop_back();
    end else if (jump) begin
      if (call) begin
        m_ras.push_back(m_pc + 32'd4);
        if (m_ras.size() > 4) void'(m_ras.pop_front());
      end
      m_pc = jt;
    end else if (br) m_pc = bt;
    else if (adv) m_pc = m_pc + 32'd4;

    if (m_mode == M_IDLE && en) m_mode = M_RUN;
    else if (m_mode == M_RUN && halt) m_mode = M_HALTED;
    else if (m_mode == M_HALTED && en) m_mode = M_RUN;
    m_valid = (m_mode == M_RUN) && !stall;
  endtask

  task automatic step(input string tag);
    bus32.en = en; bus32.halt = halt; bus32.stall = stall; bus32.fetch_ready = fr;
    bus32.exc = exc; bus32.ret = ret; bus32.jump = jump; bus32.call = call;
    bus32.branch_taken = br; bus32.jump_target = jt; bus32.branch_target = bt;
    bus8.en = en; bus8.halt = halt; bus8.stall = stall; bus8.fetch_ready = fr;
    bus8.exc = exc; bus8.ret = ret; bus8.jump = jump; bus8.call = call;
    bus8.branch_taken = br; bus8.jump_target = jt[7:0]; bus8.branch_target = bt[7:0];
    @(posedge clk);
    model_update();
    #1;
    $display("[%s] rst=%0b en=%0b halt=%0b stall=%0b rdy=%0b exc=%0b ret=%0b jmp=%0b call=%0b br=%0b -> addr=%h fv=%0b full=%0b empty=%0b uf=%0b",
             tag, rst, en, halt, stall, fr, exc, ret, jump, call, br,
             bus32.addr, bus32.fetch_valid, bus32.ras_full, bus32.ras_empty, bus32.ras_underflow);
    check({tag, ".addr"},  bus32.addr, m_pc);
    check({tag, ".valid"}, {31'b0, bus32.fetch_valid}, {31'b0, m_valid});
    check({tag, ".full"},  {31'b0, bus32.ras_full}, {31'b0, (m_ras.size() == 4)});
    check({tag, ".empty"}, {31'b0, bus32.ras_empty}, {31'b0, (m_ras.size() == 0)});
    check({tag, ".uf"},    {31'b0, bus32.ras_underflow}, {31'b0, m_uf});
  endtask

  initial begin
    clear_in();
    m_mode = M_IDLE; m_pc = '0; m_valid = 0; m_uf = 0;

    // Reset values
    rst = 1; step("reset"); step("reset"); rst = 0;
    check("rst_addr", bus32.addr, 32'd0);
    check("rst_empty", {31'b0, bus32.ras_empty}, 32'd1);

    // Start and sequential fetch
    fr = 1; en = 1; step("en");
    check("en_valid", {31'b0, bus32.fetch_valid}, 32'd1);
    check("en_addr", bus32.addr, 32'd0);
    en = 0;
    step("seq"); check("seq4", bus32.addr, 32'd4);
    step("seq"); check("seq8", bus32.addr, 32'd8);

    // Handshake back-pressure, then stall
    fr = 0; repeat (3) step("not_ready");
    check("hold_rdy", bus32.addr, 32'd8);
    fr = 1; stall = 1; repeat (3) step("stall");
    check("hold_stall", bus32.addr, 32'd8);
    stall = 0; step("unstall"); step("seq");
    check("seq12", bus32.addr, 32'd12);

    // Exception beats everything, RAS untouched
    exc = 1; jump = 1; call = 1; jt = 32'h40; br = 1; bt = 32'h60; step("exc_pri");
    check("exc_vec", bus32.addr, 32'h100);
    check("exc_ras", {31'b0, bus32.ras_empty}, 32'd1);
    clear_in(); fr = 1;

    // call/ret round trip
    jump = 1; jt = 32'h10; step("jump");
    fr = 0; call = 1; jt = 32'h80; step("call");
    check("call_tgt", bus32.addr, 32'h80);
    clear_in(); ret = 1; step("ret");
    check("ret_addr", bus32.addr, 32'h14);
    ret = 0;

    // Overfill the stack then drain past empty
    for (int i = 0; i < 5; i++) begin
      call = 1; jump = 1; jt = 32'h200 + 32'(i) * 32'h20; step("push");
    end
    check("ras_full", {31'b0, bus32.ras_full}, 32'd1);
    call = 0; jump = 0; ret = 1;
    repeat (5) step("pop");
    check("uf_addr", bus32.addr, 32'd0);
    check("uf_pulse", {31'b0, bus32.ras_underflow}, 32'd1);
    ret = 0; step("after_uf");
    check("uf_clear", {31'b0, bus32.ras_underflow}, 32'd0);

    // Halt and resume
    fr = 1; halt = 1; step("halt"); halt = 0;
    check("halt_fv", {31'b0, bus32.fetch_valid}, 32'd0);
    step("halted"); step("halted");
    en = 1; step("resume"); en = 0;
    check("resume_fv", {31'b0, bus32.fetch_valid}, 32'd1);

    // Reset mid-run with a non-empty stack
    call = 1; jump = 1; jt = 32'h300; step("push"); call = 0; jump = 0;
    check("pre_rst", {31'b0, bus32.ras_empty}, 32'd0);
    rst = 1; step("rst_mid"); rst = 0;
    check("rst_mid_addr", bus32.addr, 32'd0);
    check("rst_mid_fv", {31'b0, bus32.fetch_valid}, 32'd0);
    check("rst_mid_empty", {31'b0, bus32.ras_empty}, 32'd1);

    // Random phase
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom % 64) == 0;
      en    = ($urandom % 4) == 0;
      halt  = ($urandom % 16) == 0;
      stall = ($urandom % 5) == 0;
      fr    = ($urandom % 4) != 0;
      exc   = ($urandom % 32) == 0;
      ret   = ($urandom % 10) == 0;
      jump  = ($urandom % 8) == 0;
      call  = ($urandom % 2) == 0;
      br    = ($urandom % 8) == 0;
      jt    = $urandom;
      bt    = $urandom;
      step("rand");
    end

    // 8-bit wrap
    clear_in(); rst = 1; step("rst8"); rst = 0;
    check("w8_rst", {24'b0, bus8.addr}, 32'h00);
    fr = 1; en = 1; step("en8"); en = 0;
    jump = 1; jt = 32'hFC; step("jump8"); jump = 0;
    check("w8_fc", {24'b0, bus8.addr}, 32'hFC);
    step("wrap8");
    check("w8_wrap", {24'b0, bus8.addr}, 32'h00);
    check("w8_fv", {31'b0, bus8.fetch_valid}, 32'd1);
    step("wrap8");
    check("w8_next", {24'b0, bus8.addr}, 32'h04);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the instruction-fetch stage. It replaces the fixed-step counter with a configurable-width PC that supports a fetch handshake, stall, halt, prioritised redirects (exception, return, jump, branch) and a small return-address stack. It sits between the control unit / branch resolver and the instruction memory port.

## Interface
- ADDR_W, 32, PC width in bits
- INC, 4, sequential step added per accepted fetch
- RESET_ADDR, 0, PC value after reset and after RAS underflow
- EXC_ADDR, 'h100, exception vector
- RAS_DEPTH, 4, return-address-stack entries (power of two, ≥2)

- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- en  in  1  start fetching from IDLE
- halt  in  1  request to stop fetching
- stall  in  1  freeze PC (pipeline hazard)
- fetch_ready  in  1  instruction memory accepts addr
- fetch_valid  out  1  addr is a valid fetch request
- addr  out  ADDR_W  current PC
- exc  in  1  exception redirect to EXC_ADDR
- ret  in  1  return: pop RAS into PC
- jump  in  1  unconditional redirect to jump_target
- jump_target  in  ADDR_W  jump destination
- call  in  1  qualifies jump; push addr+INC onto RAS
- branch_taken  in  1  conditional redirect to branch_target
- branch_target  in  ADDR_W  branch destination
- ras_full  out  1  RAS holds RAS_DEPTH entries
- ras_empty  out  1  RAS holds zero entries
- ras_underflow  out  1  one-cycle pulse: ret with empty RAS

## Operation
- FSM states: IDLE, RUN, HALTED.
  - IDLE: fetch_valid=0, addr held; en=1 → RUN next cycle.
  - RUN: fetch_valid=1 unless stall=1; halt=1 → HALTED.
  - HALTED: fetch_valid=0, addr held; en=1 → RUN; redirects still update addr.
- Next-PC priority (evaluated every cycle in any state): exc > ret > jump > branch_taken > sequential > hold.
- Redirects apply regardless of stall and fetch_ready (they flush the in-flight fetch).
- Sequential advance: only in RUN when fetch_valid && fetch_ready && !stall; addr ← addr+INC, modulo 2^ADDR_W (wraps, no flag).
- call without jump ignored. call+jump: push addr+INC, addr ← jump_target.
- ret: pop top entry into addr. Empty RAS: addr ← RESET_ADDR, ras_underflow=1 for one cycle.
- Push when full: oldest entry overwritten (circular), count stays RAS_DEPTH.
- exc with call+jump or ret simultaneously: exc wins, RAS unchanged.
- ret and call+jump same cycle: ret wins, no push.

## Timing
- All outputs registered; reset values: addr=RESET_ADDR, fetch_valid=0, state IDLE, RAS count 0, ras_empty=1, ras_full=0, ras_underflow=0.
- Redirect sampled at edge N → new addr visible after edge N (one-cycle latency); fetch_valid stays 1 in RUN.
- en sampled at edge N in IDLE → fetch_valid=1 after edge N with addr unchanged.
- Handshake: addr stable while fetch_valid && !fetch_ready unless a redirect arrives.
- rst mid-operation: overrides everything at the next edge; RAS cleared.
- ras_full/ras_empty reflect count after the edge.

## Structure
- pc_pkg: FSM state encoding (IDLE=0, RUN=1, HALTED=2), next-PC select encoding, default parameter constants.
- One sub-module: pc_ras (circular LIFO, ADDR_W × RAS_DEPTH, push/pop/full/empty/underflow).
- Top pc_gen holds FSM, next-PC mux, PC register.

## Test plan
- Reset, en=1, fetch_ready=1, ADDR_W=32, INC=4 → addr 0,4,8,12 on successive cycles, fetch_valid=1.
- fetch_ready=0 for 3 cycles at addr=8 → addr holds 8; stall=1 likewise holds.
- Same cycle exc=1, jump=1 (target 0x40), branch_taken=1 → addr=0x100 next cycle, RAS unchanged.
- call+jump at addr 0x10 to 0x80, then ret → addr 0x80 then 0x14; 5 pushes with depth 4 then 5 pops → last pop sets addr=0, ras_underflow pulses once.
- ADDR_W=8, addr=0xFC, INC=4 → wraps to 0x00; halt=1 → fetch_valid=0, addr held; en=1 resumes.
- rst asserted mid-RUN with RAS non-empty → next cycle addr=RESET_ADDR, fetch_valid=0, ras_empty=1.
